// File: rtl/text_sequencer_pkg.sv
// Shared constants for the text sequencer: glyph codes, message length, FSM states.
package text_sequencer_pkg;

  localparam logic [4:0] GLYPH_G = 5'd0;
  localparam logic [4:0] GLYPH_A = 5'd1;
  localparam logic [4:0] GLYPH_M = 5'd2;
  localparam logic [4:0] GLYPH_H = 5'd3;
  localparam logic [4:0] GLYPH_I = 5'd4;
  localparam logic [4:0] GLYPH_O = 5'd5;
  localparam logic [4:0] GLYPH_V = 5'd6;
  localparam logic [4:0] GLYPH_R = 5'd7;
  localparam logic [4:0] GLYPH_E = 5'd8;
  localparam logic [4:0] BLANK   = 5'd31;

  localparam int unsigned MSG_LEN = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/text_sequencer_msg_rom.sv
// Message ROM: maps (message select, cell index) to a glyph code.
module msg_rom
  import text_sequencer_pkg::*;
(
  input  logic       msg_sel,
  input  logic [3:0] idx,
  output logic [4:0] code
);

  // Combinational lookup; 0 = "GAME OVER", 1 = "HI GAME", out-of-range cells blank
  always_comb begin
    code = BLANK;
    if (!msg_sel) begin
      case (idx)
        4'd0: code = GLYPH_G;
        4'd1: code = GLYPH_A;
        4'd2: code = GLYPH_M;
        4'd3: code = GLYPH_E;
        4'd4: code = BLANK;
        4'd5: code = GLYPH_O;
        4'd6: code = GLYPH_V;
        4'd7: code = GLYPH_E;
        4'd8: code = GLYPH_R;
        default: code = BLANK;
      endcase
    end else begin
      case (idx)
        4'd0: code = GLYPH_H;
        4'd1: code = GLYPH_I;
        4'd2: code = BLANK;
        4'd3: code = GLYPH_G;
        4'd4: code = GLYPH_A;
        4'd5: code = GLYPH_M;
        4'd6: code = GLYPH_E;
        default: code = BLANK;
      endcase
    end
  end

endmodule

// File: rtl/text_sequencer.sv
// Text sequencer: reveals a fixed message one cell per REVEAL_FRAMES frames,
// then holds it (optionally blinking); emits per-pixel glyph selection.
module text_sequencer
  import text_sequencer_pkg::*;
#(
  parameter int unsigned REVEAL_FRAMES = 8,
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned PITCH         = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        clear,
  input  logic        msg_sel,
  input  logic        blink_en,
  input  logic [9:0]  org_x,
  input  logic [9:0]  org_y,
  output logic [4:0]  select_char,
  output logic [31:0] posx,
  output logic [31:0] posy,
  output logic        char_valid,
  output logic        busy
);

  state_t      state;
  logic [3:0]  shown_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] blink_cnt;
  logic        vis;
  logic        msg_lat;

  logic [3:0]  idx;
  logic [10:0] dx;
  logic [10:0] base_off;
  logic [10:0] off;
  logic [10:0] cell_x;
  logic        in_cell;
  logic [4:0]  code;

  // Sequencer FSM: clear beats start, start restarts from any state and
  // swallows a coincident frame_tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shown_cnt <= '0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      vis       <= 1'b1;
      msg_lat   <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      shown_cnt <= '0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      vis       <= 1'b1;
      busy      <= 1'b0;
    end else if (start) begin
      state     <= REVEAL;
      msg_lat   <= msg_sel;
      shown_cnt <= 4'd1;
      frame_cnt <= '0;
      blink_cnt <= '0;
      vis       <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        REVEAL: begin
          if (frame_tick) begin
            if (frame_cnt == 16'(REVEAL_FRAMES - 1)) begin
              frame_cnt <= '0;
              shown_cnt <= shown_cnt + 4'd1;
              if (shown_cnt + 4'd1 == 4'(MSG_LEN)) begin
                state <= HOLD;
                busy  <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        HOLD: begin
          if (!blink_en) begin
            blink_cnt <= '0;
            vis       <= 1'b1;
          end else if (frame_tick) begin
            if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
              blink_cnt <= '0;
              vis       <= ~vis;
            end else begin
              blink_cnt <= blink_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Cell decode: idx is the last cell whose left edge is at or before x,
  // found by comparison instead of a divide; 11-bit math avoids wrap
  always_comb begin
    dx       = {1'b0, x} - {1'b0, org_x};
    idx      = '0;
    base_off = '0;
    if (x >= org_x) begin
      for (int unsigned k = 1; k < MSG_LEN; k++) begin
        if (dx >= 11'(k * PITCH)) begin
          idx      = 4'(k);
          base_off = 11'(k * PITCH);
        end
      end
    end
    off     = dx - base_off;
    cell_x  = {1'b0, org_x} + base_off;
    in_cell = (x >= org_x) && (off <= 11'd9) &&
              ({1'b0, y} >= {1'b0, org_y}) &&
              ({1'b0, y} <= {1'b0, org_y} + 11'd19);
  end

  msg_rom u_msg_rom (
    .msg_sel (msg_lat),
    .idx     (idx),
    .code    (code)
  );

  // Registered pixel outputs, one cycle behind x/y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select_char <= BLANK;
      posx        <= '0;
      posy        <= '0;
      char_valid  <= 1'b0;
    end else begin
      select_char <= in_cell ? code : BLANK;
      posx        <= {21'd0, cell_x};
      posy        <= {22'd0, org_y};
      char_valid  <= in_cell && (idx < shown_cnt) && (code != BLANK) &&
                     vis && (state != IDLE);
    end
  end

endmodule
